// File: rtl/fsm_traffic_light.sv
// Traffic-light controller for a main/side street crossing with a pedestrian walk phase.
// Phase timing runs in ticks from an internal divider; a latched walk request inserts
// an all-red WALK phase after main yellow. Optional macro WALK_FLASH_EN blinks
// walk_light once during the last tick period of WALK.
module fsm_traffic_light #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       walk,
  input  logic       sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMR_W = 3;

  localparam logic [2:0] S_MG     = 3'd0;
  localparam logic [2:0] S_MG_EXT = 3'd1;
  localparam logic [2:0] S_MY     = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_SG     = 3'd4;
  localparam logic [2:0] S_SG_EXT = 3'd5;
  localparam logic [2:0] S_SY     = 3'd6;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       state_q, state_d;
  logic             walk_latch_q, walk_latch_d;
  logic [2:0]       main_light_q, main_light_d;
  logic [2:0]       side_light_q, side_light_d;
  logic             walk_light_q, walk_light_d;

  logic             tick;
  logic             illegal;
  logic [TMR_W-1:0] last_tick;
  logic [2:0]       exit_state;
  logic             enter_walk;

  // Free-running tick divider, wraps at TICK_DIV-1
  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Per-state duration and exit target
  always_comb begin
    illegal    = 1'b0;
    last_tick  = TMR_W'(0);
    exit_state = S_MG;
    case (state_q)
      S_MG:     begin last_tick = TMR_W'(5); exit_state = sensor ? S_MG_EXT : S_MY; end
      S_MG_EXT: begin last_tick = TMR_W'(2); exit_state = S_MY; end
      S_MY:     begin last_tick = TMR_W'(1); exit_state = walk_latch_q ? S_WALK : S_SG; end
      S_WALK:   begin last_tick = TMR_W'(2); exit_state = S_SG; end
      S_SG:     begin last_tick = TMR_W'(5); exit_state = sensor ? S_SG_EXT : S_SY; end
      S_SG_EXT: begin last_tick = TMR_W'(2); exit_state = S_SY; end
      S_SY:     begin last_tick = TMR_W'(1); exit_state = S_MG; end
      default:  illegal = 1'b1;
    endcase
  end

  // Next state and phase timer; transitions only on tick, illegal codes recover at once
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (illegal) begin
      state_d = S_MG;
      timer_d = '0;
    end else if (tick) begin
      if (timer_q == last_tick) begin
        state_d = exit_state;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  // Walk request latch; clear on WALK entry wins over a simultaneous press
  always_comb begin
    enter_walk   = (state_d == S_WALK) && (state_q != S_WALK);
    walk_latch_d = enter_walk ? 1'b0 : (walk_latch_q | walk);
  end

  // Output decode from the next state so registered outputs track the state register
  always_comb begin
    main_light_d = L_GREEN;
    side_light_d = L_RED;
    walk_light_d = 1'b0;
    case (state_d)
      S_MG, S_MG_EXT: begin main_light_d = L_GREEN;  side_light_d = L_RED;    end
      S_MY:           begin main_light_d = L_YELLOW; side_light_d = L_RED;    end
      S_WALK: begin
        main_light_d = L_RED;
        side_light_d = L_RED;
`ifdef WALK_FLASH_EN
        walk_light_d = !((timer_d == TMR_W'(2)) && (cnt_d >= CNT_W'(TICK_DIV / 2)));
`else
        walk_light_d = 1'b1;
`endif
      end
      S_SG, S_SG_EXT: begin main_light_d = L_RED;    side_light_d = L_GREEN;  end
      S_SY:           begin main_light_d = L_RED;    side_light_d = L_YELLOW; end
      default:        begin main_light_d = L_GREEN;  side_light_d = L_RED;    end
    endcase
  end

  // State, timer, divider, latch and output registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      timer_q      <= '0;
      state_q      <= S_MG;
      walk_latch_q <= 1'b0;
      main_light_q <= L_GREEN;
      side_light_q <= L_RED;
      walk_light_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      state_q      <= state_d;
      walk_latch_q <= walk_latch_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      walk_light_q <= walk_light_d;
    end
  end

  assign main_light = main_light_q;
  assign side_light = side_light_q;
  assign walk_light = walk_light_q;

endmodule

// File: tb/tb_fsm_traffic_light.sv
// Bench for fsm_traffic_light: table-driven phase sequences, async reset mid-SG,
// and randomized walk/sensor/reset traffic checked against a phase-level model.
module tb_fsm_traffic_light;

  localparam int TD = 4;
`ifdef WALK_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       walk  = 1'b0;
  logic       sensor = 1'b0;
  logic [2:0] main_light, side_light;
  logic       walk_light;

  fsm_traffic_light #(.TICK_DIV(TD)) dut (
    .clock      (clock),
    .rst        (rst),
    .walk       (walk),
    .sensor     (sensor),
    .main_light (main_light),
    .side_light (side_light),
    .walk_light (walk_light)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- phase-level reference model ----------------
  // Phases: 0 MG, 1 MG_EXT, 2 MY, 3 WALK, 4 SG, 5 SG_EXT, 6 SY
  int dur [7] = '{6, 3, 2, 3, 6, 3, 2};
  int m_ph, m_ticks, m_cyc;
  bit m_latch;

  function automatic int next_phase(int ph, bit sens, bit lat);
    case (ph)
      0: return sens ? 1 : 2;
      1: return 2;
      2: return lat ? 3 : 4;
      3: return 4;
      4: return sens ? 5 : 6;
      5: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ticks = 0; m_cyc = 0; m_latch = 1'b0;
  endtask

  task automatic model_edge();
    int nph;
    bit tick;
    if (!rst) begin
      model_reset();
    end else begin
      tick = (m_cyc % TD) == TD - 1;
      nph = m_ph;
      if (tick) begin
        if (m_ticks + 1 == dur[m_ph]) begin
          nph = next_phase(m_ph, sensor, m_latch);
          m_ticks = 0;
        end else begin
          m_ticks++;
        end
      end
      if (nph == 3 && m_ph != 3) m_latch = 1'b0;
      else m_latch = m_latch | walk;
      m_ph = nph;
      m_cyc++;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] m, s;
    logic w;
    w = 1'b0;
    case (m_ph)
      0, 1: begin m = G; s = R; end
      2:    begin m = Y; s = R; end
      3:    begin m = R; s = R;
                  w = !(FLASH && m_ticks == 2 && (m_cyc % TD) >= TD / 2); end
      4, 5: begin m = R; s = G; end
      default: begin m = R; s = Y; end
    endcase
    return {m, s, w};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(string name, logic [6:0] exp);
    logic [6:0] act;
    act = {main_light, side_light, walk_light};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got main=%b side=%b walk=%b, expected main=%b side=%b walk=%b",
               name, $time, act[6:4], act[3:1], act[0], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  // One clock: model follows the rising edge, bench resumes on the falling edge
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    bit         do_rst;
    bit         w_in;
    bit         s_in;
    int         n;
    logic [2:0] m;
    logic [2:0] s;
    bit         w;
  } row_t;

  row_t rows[$];

  task automatic add(bit r, bit wi, bit si, int n, logic [2:0] m, logic [2:0] s, bit w);
    row_t x;
    x.do_rst = r; x.w_in = wi; x.s_in = si; x.n = n; x.m = m; x.s = s; x.w = w;
    rows.push_back(x);
  endtask

  task automatic add_walk(bit wi, bit si);
    add(0, wi, si, 10, R, R, 1'b1);
    add(0, wi, si, 2,  R, R, !FLASH);
  endtask

  task automatic run_rows(string tag);
    foreach (rows[i]) begin
      if (rows[i].do_rst) do_reset();
      walk   = rows[i].w_in;
      sensor = rows[i].s_in;
      for (int k = 0; k < rows[i].n; k++) begin
        check($sformatf("%s_row%0d_cyc%0d", tag, i, k), {rows[i].m, rows[i].s, rows[i].w});
        step();
      end
    end
    rows.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    @(negedge clock);
    check("reset_state", {G, R, 1'b0});

    // Idle rotation
    add(1, 0, 0, 24, G, R, 0); add(0, 0, 0, 8, Y, R, 0);
    add(0, 0, 0, 24, R, G, 0); add(0, 0, 0, 8, R, Y, 0);
    add(0, 0, 0, 1,  G, R, 0);
    run_rows("idle");

    // Sensor extension on both greens
    add(1, 0, 1, 36, G, R, 0); add(0, 0, 1, 8, Y, R, 0);
    add(0, 0, 1, 36, R, G, 0); add(0, 0, 1, 8, R, Y, 0);
    add(0, 0, 1, 1,  G, R, 0);
    run_rows("sensor");

    // Single walk pulse served once
    add(1, 0, 0, 5, G, R, 0); add(0, 1, 0, 1, G, R, 0); add(0, 0, 0, 18, G, R, 0);
    add(0, 0, 0, 8, Y, R, 0); add_walk(0, 0);
    add(0, 0, 0, 24, R, G, 0); add(0, 0, 0, 8, R, Y, 0);
    add(0, 0, 0, 24, G, R, 0); add(0, 0, 0, 8, Y, R, 0);
    add(0, 0, 0, 24, R, G, 0);
    run_rows("walk_pulse");

    // Walk held: WALK on every rotation
    add(1, 1, 0, 24, G, R, 0); add(0, 1, 0, 8, Y, R, 0); add_walk(1, 0);
    add(0, 1, 0, 24, R, G, 0); add(0, 1, 0, 8, R, Y, 0);
    add(0, 1, 0, 24, G, R, 0); add(0, 1, 0, 8, Y, R, 0); add_walk(1, 0);
    add(0, 1, 0, 1,  R, G, 0);
    run_rows("walk_held");

    // Asynchronous reset in the middle of SG
    do_reset();
    walk = 1'b0; sensor = 1'b0;
    for (int k = 0; k < 24 + 8 + 5; k++) step();
    check("pre_async_in_sg", {R, G, 1'b0});
    #1 rst = 1'b0;
    #1 check("async_rst_immediate", {G, R, 1'b0});
    model_reset();
    @(negedge clock);
    step();
    rst = 1'b1;
    add(0, 0, 0, 24, G, R, 0); add(0, 0, 0, 8, Y, R, 0);
    run_rows("after_async");

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      walk = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) sensor = ~sensor;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end
      check("random_vs_model", model_out());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
